// File: rtl/saradc_sar_ctrl.sv
// Successive-approximation control for the SAR ADC: sample, NBITS settle/latch trials,
// optional 2^k conversion averaging with truncated mean on dout.
module saradc_sar_ctrl #(
  parameter int NBITS      = 8,
  parameter int SAMPLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       avg_log2,
  input  logic             cmp,
  output logic             smpl,
  output logic             cmp_en,
  output logic [NBITS-1:0] dac,
  output logic             busy,
  output logic [NBITS-1:0] dout,
  output logic             valid
);

  localparam int IW = $clog2(NBITS);
  localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam int AW = NBITS + 3;

  localparam logic [SW-1:0]    SampleLast = SW'(SAMPLE_CYC - 1);
  localparam logic [IW-1:0]    TopIdx     = IW'(NBITS - 1);
  localparam logic [NBITS-1:0] MsbCode    = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] OneCode    = {{(NBITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle,
    StSample,
    StSettle,
    StLatch,
    StAcc,
    StDone
  } state_t;

  state_t           state;
  logic [1:0]       k;
  logic [2:0]       cnt;
  logic [SW-1:0]    scnt;
  logic [IW-1:0]    bidx;
  logic [NBITS-1:0] code;
  logic [AW-1:0]    acc;

  logic [NBITS-1:0] bit_mask;
  logic [NBITS-1:0] code_kept;
  logic [NBITS-1:0] trial_next;
  logic [AW-1:0]    acc_sum;
  logic [2:0]       last_cnt;
  logic [NBITS-1:0] mean;

  always_comb begin
    bit_mask   = OneCode << bidx;
    code_kept  = cmp ? code : (code & ~bit_mask);
    // Next trial bit sits one position below the one just decided.
    trial_next = code_kept | (bit_mask >> 1);
    acc_sum    = acc + AW'(code);
    last_cnt   = 3'((4'd1 << k) - 4'd1);
    mean       = NBITS'(acc_sum >> k);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= StIdle;
      k      <= '0;
      cnt    <= '0;
      scnt   <= '0;
      bidx   <= '0;
      code   <= '0;
      acc    <= '0;
      smpl   <= 1'b0;
      cmp_en <= 1'b0;
      dac    <= '0;
      busy   <= 1'b0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            k     <= avg_log2;
            acc   <= '0;
            cnt   <= '0;
            scnt  <= '0;
            smpl  <= 1'b1;
            busy  <= 1'b1;
            dac   <= '0;
            state <= StSample;
          end
        end
        StSample: begin
          if (scnt == SampleLast) begin
            smpl  <= 1'b0;
            bidx  <= TopIdx;
            code  <= MsbCode;
            dac   <= MsbCode;
            state <= StSettle;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        StSettle: begin
          cmp_en <= 1'b1;
          state  <= StLatch;
        end
        StLatch: begin
          cmp_en <= 1'b0;
          if (bidx != '0) begin
            code  <= trial_next;
            dac   <= trial_next;
            bidx  <= bidx - 1'b1;
            state <= StSettle;
          end else begin
            code  <= code_kept;
            dac   <= code_kept;
            state <= StAcc;
          end
        end
        StAcc: begin
          acc <= acc_sum;
          dac <= '0;
          if (cnt != last_cnt) begin
            cnt   <= cnt + 1'b1;
            scnt  <= '0;
            smpl  <= 1'b1;
            state <= StSample;
          end else begin
            dout  <= mean;
            valid <= 1'b1;
            state <= StDone;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Bench for saradc_sar_ctrl: behavioural comparator, table-driven conversions on an
// 8-bit instance plus corner sequences and a 4-bit / 12-bit parameter sweep.
module tb_saradc_sar_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [2:0] st;
  logic [1:0] av;

  logic [11:0] vq [3][8];
  logic [2:0]  ci0 = '0, ci1 = '0, ci2 = '0;
  logic [2:0]  p0, p1, p2;

  logic smpl0, cmp_en0, busy0, valid0, cmp0;
  logic smpl1, cmp_en1, busy1, valid1, cmp1;
  logic smpl2, cmp_en2, busy2, valid2, cmp2;
  logic [7:0]  dac0, dout0;
  logic [3:0]  dac1, dout1;
  logic [11:0] dac2, dout2;

  saradc_sar_ctrl #(.NBITS(8), .SAMPLE_CYC(2)) u_dut (
    .clk(clk), .rstn(rstn), .start(st[0]), .avg_log2(av), .cmp(cmp0),
    .smpl(smpl0), .cmp_en(cmp_en0), .dac(dac0), .busy(busy0), .dout(dout0), .valid(valid0)
  );
  saradc_sar_ctrl #(.NBITS(4), .SAMPLE_CYC(1)) u_n4 (
    .clk(clk), .rstn(rstn), .start(st[1]), .avg_log2(av), .cmp(cmp1),
    .smpl(smpl1), .cmp_en(cmp_en1), .dac(dac1), .busy(busy1), .dout(dout1), .valid(valid1)
  );
  saradc_sar_ctrl #(.NBITS(12), .SAMPLE_CYC(4)) u_n12 (
    .clk(clk), .rstn(rstn), .start(st[2]), .avg_log2(av), .cmp(cmp2),
    .smpl(smpl2), .cmp_en(cmp_en2), .dac(dac2), .busy(busy2), .dout(dout2), .valid(valid2)
  );

  // Each sampling pulse advances to the next queued input voltage.
  always @(posedge smpl0) ci0 <= ci0 + 3'd1;
  always @(posedge smpl1) ci1 <= ci1 + 3'd1;
  always @(posedge smpl2) ci2 <= ci2 + 3'd1;
  assign p0 = ci0 - 3'd1;
  assign p1 = ci1 - 3'd1;
  assign p2 = ci2 - 3'd1;
  assign cmp0 = (vq[0][p0] >= 12'(dac0));
  assign cmp1 = (vq[1][p1] >= 12'(dac1));
  assign cmp2 = (vq[2][p2] >= 12'(dac2));

  int sel;
  logic sm, ce, bz, vl;
  logic [11:0] dc, dt;
  logic [2:0]  ci_m;
  always_comb begin
    sm = smpl0; ce = cmp_en0; bz = busy0; vl = valid0;
    dc = 12'(dac0); dt = 12'(dout0); ci_m = ci0;
    case (sel)
      1: begin
        sm = smpl1; ce = cmp_en1; bz = busy1; vl = valid1;
        dc = 12'(dac1); dt = 12'(dout1); ci_m = ci1;
      end
      2: begin
        sm = smpl2; ce = cmp_en2; bz = busy2; vl = valid2;
        dc = 12'(dac2); dt = 12'(dout2); ci_m = ci2;
      end
      default: ;
    endcase
  end

  int total = 0;
  int bad   = 0;
  int trials [$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One accepted start on instance inst; cycle 1 is the first cycle after the accepting edge.
  task automatic convert(input int inst, input int k, input int vins[8], input int pa,
                         input int pb, output int vcyc, output int res, output int npulse,
                         output int nhigh, output int nvalid, output int busy_err);
    int base, cyc;
    logic prev;
    sel = inst;
    vcyc = -1; res = -1; npulse = 0; nhigh = 0; nvalid = 0; busy_err = 0;
    trials.delete();
    @(negedge clk);
    base = int'(ci_m);
    for (int j = 0; j < 8; j++) vq[inst][(base + j) % 8] = 12'(vins[j]);
    av = 2'(k);
    st[inst] = 1'b1;
    @(posedge clk);
    #1;
    st[inst] = 1'b0;
    cyc = 1;
    prev = 1'b0;
    while (cyc < 2000) begin
      if (sm) nhigh++;
      if (sm && !prev) npulse++;
      prev = sm;
      if (ce) trials.push_back(int'(dc));
      if (vl) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc = cyc;
          res  = int'(dt);
        end
      end
      if ((vcyc < 0 || cyc == vcyc) && !bz) busy_err++;
      if (vcyc >= 0 && cyc > vcyc && bz) busy_err++;
      st[inst] = (cyc == pa || cyc == pb);
      if (vcyc >= 0 && cyc >= vcyc + 3) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    st[inst] = 1'b0;
  endtask

  typedef struct {
    int k;
    int v[8];
    int exp;
  } vec_t;

  vec_t tbl[7];
  int   trial_exp[8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  initial begin
    int vcyc, res, npulse, nhigh, nvalid, berr, kk, nb, sc, sum, cyc, v1, v2, nv;
    int vins[8];

    tbl[0] = '{0, '{165, 0, 0, 0, 0, 0, 0, 0}, 165};
    tbl[1] = '{0, '{255, 0, 0, 0, 0, 0, 0, 0}, 255};
    tbl[2] = '{0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0};
    tbl[3] = '{2, '{100, 101, 102, 103, 0, 0, 0, 0}, 101};
    tbl[4] = '{1, '{10, 13, 0, 0, 0, 0, 0, 0}, 11};
    tbl[5] = '{3, '{0, 1, 2, 3, 4, 5, 6, 7}, 3};
    tbl[6] = '{3, '{255, 255, 255, 255, 255, 255, 255, 255}, 255};

    for (int i = 0; i < 3; i++) for (int j = 0; j < 8; j++) vq[i][j] = '0;
    sel = 0; st = '0; av = '0; rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset smpl", int'(smpl0), 0);
    chk("reset cmp_en", int'(cmp_en0), 0);
    chk("reset dac", int'(dac0), 0);
    chk("reset busy", int'(busy0), 0);
    chk("reset valid", int'(valid0), 0);
    chk("reset dout", int'(dout0), 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      convert(0, tbl[i].k, tbl[i].v, 0, 0, vcyc, res, npulse, nhigh, nvalid, berr);
      chk($sformatf("vec%0d dout", i), res, tbl[i].exp);
      chk($sformatf("vec%0d valid cycle", i), vcyc, (1 << tbl[i].k) * 19 + 1);
      chk($sformatf("vec%0d smpl pulses", i), npulse, 1 << tbl[i].k);
      chk($sformatf("vec%0d smpl cycles", i), nhigh, 2 * (1 << tbl[i].k));
      chk($sformatf("vec%0d valid count", i), nvalid, 1);
      chk($sformatf("vec%0d busy window", i), berr, 0);
      if (i == 0) begin
        chk("trial count", trials.size(), 8);
        for (int j = 0; j < 8 && j < trials.size(); j++)
          chk($sformatf("trial %0d dac", j), trials[j], trial_exp[j]);
      end
    end

    // Starts arriving mid-conversion are dropped.
    vins = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    convert(0, 0, vins, 5, 12, vcyc, res, npulse, nhigh, nvalid, berr);
    chk("ignore-start dout", res, 8'h5A);
    chk("ignore-start valid cycle", vcyc, 20);
    chk("ignore-start valid count", nvalid, 1);
    chk("ignore-start busy", berr, 0);

    // Reset in cycle 10 aborts the conversion silently.
    sel = 0;
    @(negedge clk);
    for (int j = 0; j < 8; j++) vq[0][j] = 12'h03C;
    av = 2'd0;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    #1;
    chk("abort smpl", int'(smpl0), 0);
    chk("abort cmp_en", int'(cmp_en0), 0);
    chk("abort dac", int'(dac0), 0);
    chk("abort busy", int'(busy0), 0);
    chk("abort dout", int'(dout0), 0);
    nv = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (valid0) nv++;
    end
    @(negedge clk);
    rstn = 1'b1;
    vins = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    convert(0, 0, vins, 0, 0, vcyc, res, npulse, nhigh, nvalid, berr);
    chk("post-reset dout", res, 8'h3C);
    chk("post-reset valid cycle", vcyc, 20);
    chk("post-reset valid count", nvalid + nv, 1);

    // Start held high: valid period is C + 2.
    sel = 0;
    @(negedge clk);
    for (int j = 0; j < 8; j++) vq[0][j] = 12'h077;
    av = 2'd0;
    st[0] = 1'b1;
    v1 = -1; v2 = -1; cyc = 0;
    while (cyc < 200 && v2 < 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid0) begin
        if (v1 < 0) v1 = cyc;
        else v2 = cyc;
      end
    end
    st[0] = 1'b0;
    chk("back-to-back period", v2 - v1, 21);
    chk("back-to-back dout", int'(dout0), 8'h77);
    cyc = 0;
    while (cyc < 100 && busy0) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("back-to-back drain", int'(busy0), 0);

    for (int inst = 1; inst < 3; inst++) begin
      nb = (inst == 1) ? 4 : 12;
      sc = (inst == 1) ? 1 : 4;
      for (int r = 0; r < 4; r++) begin
        kk = $urandom_range(0, 3);
        sum = 0;
        for (int j = 0; j < 8; j++) begin
          vins[j] = $urandom_range(0, (1 << nb) - 1);
          if (j < (1 << kk)) sum += vins[j];
        end
        convert(inst, kk, vins, 0, 0, vcyc, res, npulse, nhigh, nvalid, berr);
        chk($sformatf("sweep n%0d r%0d dout", nb, r), res, sum >> kk);
        chk($sformatf("sweep n%0d r%0d valid cycle", nb, r), vcyc,
            (1 << kk) * (sc + 2 * nb + 1) + 1);
        chk($sformatf("sweep n%0d r%0d smpl cycles", nb, r), nhigh, sc * (1 << kk));
        chk($sformatf("sweep n%0d r%0d valid count", nb, r), nvalid, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
